// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter.
// One frame per handshake: start, data LSB first, optional parity, stop bits.
module uart_tx_cfg #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              txd,
    output logic              busy,
    output logic              done
);

    localparam int CW_RAW = $clog2(CLKS_PER_BIT + 1);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam int BW     = $clog2(DATA_W + 1);

    localparam logic [CW-1:0] T_LOAD    = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_W - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     tmr_q, tmr_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              txd_q, txd_d;
    logic              done_q, done_d;
    logic              tick;

    assign tick = (tmr_q == '0);

    // State register; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered outputs; txd idles high, also during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            tmr_q   <= tmr_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            done_q  <= done_d;
        end
    end

    // Next state: bit timer, bit counter and shift register sequencing.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_START;
                    tmr_d   = T_LOAD;
                    bit_d   = '0;
                    shift_d = in_data;
                    par_d   = (PARITY == 1) ? ~^in_data : ^in_data;
                end
            end
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                    tmr_d   = T_LOAD;
                    bit_d   = '0;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_DATA: begin
                if (tick) begin
                    tmr_d   = T_LOAD;
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_DATA) begin
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_PAR: begin
                if (tick) begin
                    state_d = S_STOP;
                    tmr_d   = T_LOAD;
                    bit_d   = '0;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (bit_q == LAST_STOP) begin
                        state_d = S_IDLE;
                        bit_d   = '0;
                    end else begin
                        tmr_d = T_LOAD;
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tmr_d   = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Outputs: txd is registered from the state being entered.
    always_comb begin
        txd_d  = 1'b1;
        done_d = (state_q == S_STOP) && (state_d == S_IDLE);
        case (state_d)
            S_IDLE:  txd_d = 1'b1;
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_d[0];
            S_PAR:   txd_d = par_d;
            S_STOP:  txd_d = 1'b1;
            default: txd_d = 1'b1;
        endcase
    end

    assign txd      = txd_q;
    assign done     = done_q;
    assign in_ready = (state_q == S_IDLE);
    assign busy     = (state_q == S_START) || (state_q == S_DATA) ||
                      (state_q == S_PAR) || (state_q == S_STOP);

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: five configurations of uart_tx_cfg, directed frames.
// Stimulus queues expected frames; a negedge monitor checks the line.
module tb_uart_tx_cfg;

    localparam int NC = 5;
    localparam int DW_A  [NC] = '{8, 8, 8, 8, 5};
    localparam int CPB_A [NC] = '{4, 4, 4, 1, 3};
    localparam int PAR_A [NC] = '{0, 2, 1, 0, 1};
    localparam int STP_A [NC] = '{1, 1, 1, 2, 1};

    typedef struct {
        int          cfg;
        int          nbits;
        logic [12:0] bits;
        int          gap;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NC-1:0] in_valid = '0;
    logic [8:0]    in_data [NC];
    logic [NC-1:0] in_ready, txd, busy, done;

    exp_t exp_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   timeouts = 0;
    bit   fin = 1'b0;
    bit   fin_done = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NC; g++) begin : g_dut
        uart_tx_cfg #(
            .DATA_W      (DW_A[g]),
            .CLKS_PER_BIT(CPB_A[g]),
            .PARITY      (PAR_A[g]),
            .STOP_BITS   (STP_A[g])
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .in_valid(in_valid[g]),
            .in_data (in_data[g][DW_A[g]-1:0]),
            .in_ready(in_ready[g]),
            .txd     (txd[g]),
            .busy    (busy[g]),
            .done    (done[g])
        );
    end

    function automatic void expect_frame(int g, int n, logic [12:0] b, int gap);
        exp_t e;
        e.cfg   = g;
        e.nbits = n;
        e.bits  = b;
        e.gap   = gap;
        exp_q.push_back(e);
    endfunction

    task automatic send(int g, logic [8:0] d, bit hold);
        bit ok;
        ok = 1'b0;
        in_data[g]  = d;
        in_valid[g] = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (in_ready[g]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            timeouts++;
            in_valid[g] = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            if (!hold) in_valid[g] = 1'b0;
        end
    endtask

    // Monitor state, one slot per configuration.
    bit   act [NC];
    bit   skip [NC];
    bit   rst_seen [NC];
    int   cyc [NC];
    int   idle_cnt [NC];
    int   ferr [NC];
    int   first_bad [NC];
    int   idle_err [NC];
    exp_t cur [NC];

    task automatic wait_idle(int g);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy[g] && !act[g]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeouts++;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Stimulus: directed frames with hand-computed line images.
    initial begin
        for (int g = 0; g < NC; g++) in_data[g] = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        expect_frame(0, 10, 13'({1'b1, 8'hA5, 1'b0}), -1);
        send(0, 9'h0A5, 1'b0);
        wait_idle(0);

        expect_frame(1, 11, 13'({1'b1, 1'b1, 8'h07, 1'b0}), -1);
        send(1, 9'h007, 1'b0);
        wait_idle(1);
        expect_frame(1, 11, 13'({1'b1, 1'b0, 8'h00, 1'b0}), -1);
        send(1, 9'h000, 1'b0);
        wait_idle(1);

        expect_frame(2, 11, 13'({1'b1, 1'b0, 8'h07, 1'b0}), -1);
        send(2, 9'h007, 1'b0);
        wait_idle(2);

        expect_frame(3, 11, 13'({2'b11, 8'h00, 1'b0}), -1);
        expect_frame(3, 11, 13'({2'b11, 8'hFF, 1'b0}), 1);
        send(3, 9'h000, 1'b1);
        send(3, 9'h0FF, 1'b0);
        wait_idle(3);

        expect_frame(4, 8, 13'({1'b1, 1'b0, 5'h1F, 1'b0}), -1);
        send(4, 9'h01F, 1'b0);
        wait_idle(4);
        expect_frame(4, 8, 13'({1'b1, 1'b1, 5'h05, 1'b0}), -1);
        send(4, 9'h005, 1'b0);
        wait_idle(4);

        expect_frame(0, 10, 13'({1'b1, 8'h3C, 1'b0}), -1);
        send(0, 9'h03C, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        in_data[0]  = 9'h0FF;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
        wait_idle(0);

        expect_frame(0, 10, 13'({1'b1, 8'h5A, 1'b0}), -1);
        send(0, 9'h05A, 1'b0);
        repeat (17) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        expect_frame(0, 10, 13'({1'b1, 8'hC3, 1'b0}), -1);
        send(0, 9'h0C3, 1'b0);
        wait_idle(0);

        repeat (5) @(posedge clk);
        fin = 1'b1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run still active at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    // Monitor: follows txd per configuration, checks against queued frames.
    always @(negedge clk) begin
        if (!fin_done) begin
            for (int g = 0; g < NC; g++) begin
                if (!rst_n) begin
                    act[g]      = 1'b0;
                    skip[g]     = 1'b0;
                    idle_cnt[g] = 0;
                    if (!rst_seen[g]) begin
                        rst_seen[g] = 1'b1;
                        total_cnt++;
                        if (txd[g] === 1'b1 && busy[g] === 1'b0 &&
                            done[g] === 1'b0 && in_ready[g] === 1'b1)
                            pass_cnt++;
                        else
                            $display("FAIL reset_state cfg%0d: txd=%b busy=%b done=%b in_ready=%b, required 1 0 0 1",
                                     g, txd[g], busy[g], done[g], in_ready[g]);
                    end
                end else begin
                    rst_seen[g] = 1'b0;
                    if (skip[g]) begin
                        if (!busy[g] && txd[g] === 1'b1) skip[g] = 1'b0;
                    end else if (!act[g]) begin
                        if (txd[g] === 1'b0) begin
                            if (exp_q.size() == 0 || exp_q[0].cfg != g) begin
                                total_cnt++;
                                $display("FAIL unexpected_frame cfg%0d: start bit seen at %0t, required idle line",
                                         g, $time);
                                skip[g] = 1'b1;
                            end else begin
                                cur[g]  = exp_q.pop_front();
                                act[g]  = 1'b1;
                                cyc[g]  = 0;
                                ferr[g] = 0;
                                if (cur[g].gap >= 0) begin
                                    total_cnt++;
                                    if (idle_cnt[g] == cur[g].gap)
                                        pass_cnt++;
                                    else
                                        $display("FAIL frame_gap cfg%0d: %0d idle clks, required %0d",
                                                 g, idle_cnt[g], cur[g].gap);
                                end
                            end
                        end else begin
                            if (busy[g] !== 1'b0 || done[g] !== 1'b0 ||
                                in_ready[g] !== 1'b1) begin
                                if (idle_err[g] < 3)
                                    $display("idle violation cfg%0d at %0t: busy=%b done=%b in_ready=%b",
                                             g, $time, busy[g], done[g], in_ready[g]);
                                idle_err[g]++;
                            end
                            idle_cnt[g]++;
                        end
                    end
                    if (act[g]) begin
                        if (cyc[g] < cur[g].nbits * CPB_A[g]) begin
                            if (txd[g] !== cur[g].bits[cyc[g] / CPB_A[g]] ||
                                busy[g] !== 1'b1 || in_ready[g] !== 1'b0 ||
                                done[g] !== 1'b0) begin
                                if (ferr[g] == 0) first_bad[g] = cyc[g];
                                ferr[g]++;
                            end
                            cyc[g]++;
                        end else begin
                            total_cnt++;
                            if (ferr[g] == 0 && done[g] === 1'b1 &&
                                busy[g] === 1'b0 && txd[g] === 1'b1)
                                pass_cnt++;
                            else
                                $display("FAIL frame cfg%0d bits=%h: %0d bad clks (first %0d), done=%b busy=%b at clk %0d, required clean line and done=1 busy=0",
                                         g, cur[g].bits, ferr[g], first_bad[g],
                                         done[g], busy[g], cyc[g]);
                            act[g]      = 1'b0;
                            idle_cnt[g] = 1;
                        end
                    end
                end
            end
            if (fin) begin
                fin_done = 1'b1;
                total_cnt++;
                if (exp_q.size() == 0)
                    pass_cnt++;
                else
                    $display("FAIL frames_sent: %0d frames still expected, required 0",
                             exp_q.size());
                total_cnt++;
                if (timeouts == 0)
                    pass_cnt++;
                else
                    $display("FAIL handshake_wait: %0d timeouts, required 0", timeouts);
                for (int g = 0; g < NC; g++) begin
                    total_cnt++;
                    if (idle_err[g] == 0)
                        pass_cnt++;
                    else
                        $display("FAIL idle_line cfg%0d: %0d bad idle clks, required 0",
                                 g, idle_err[g]);
                end
                $display("%0d/%0d checks passed", pass_cnt, total_cnt);
                $finish;
            end
        end
    end

endmodule
